// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential 14-bit binary to 4-digit BCD converter using a
//                shift-and-add-3 (double-dabble) engine, one bit per clock.
//                Drives the quad seven-segment display driver with registered
//                digits that only change when a conversion completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W       = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [3:0]   dig_3,
    output logic [3:0]   dig_2,
    output logic [3:0]   dig_1,
    output logic [3:0]   dig_0,
    output logic         dot_3,
    output logic         dot_2,
    output logic         dot_1,
    output logic         dot_0
);

    localparam logic [W-1:0] c_max_val = W'(MAX_VAL);
    localparam logic [3:0]   c_last    = 4'(W - 1);
    localparam logic [3:0]   c_nine    = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_bin;
    logic [15:0]    r_bcd;
    logic [3:0]     r_cnt;
    logic           r_ovf_pend;
    logic [15:0]    w_bcd_adj;

    // Add-3 correction: any nibble of 5 or more would exceed 9 after doubling
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                     (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
    end

    // Control FSM, shift engine and registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            dig_3      <= '0;
            dig_2      <= '0;
            dig_1      <= '0;
            dig_0      <= '0;
            dot_3      <= 1'b0;
            dot_2      <= 1'b0;
            dot_1      <= 1'b0;
            dot_0      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin      <= bin;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (bin > c_max_val);
                        busy       <= 1'b1;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    // Corrected scratch and remaining binary bits shift as one word
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 4'd1;
                    if (r_cnt == c_last) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Out-of-range values saturate the display at 9999
                    if (r_ovf_pend) begin
                        dig_3 <= c_nine;
                        dig_2 <= c_nine;
                        dig_1 <= c_nine;
                        dig_0 <= c_nine;
                    end else begin
                        dig_3 <= r_bcd[15:12];
                        dig_2 <= r_bcd[11:8];
                        dig_1 <= r_bcd[7:4];
                        dig_0 <= r_bcd[3:0];
                    end
                    overflow <= r_ovf_pend;
                    dot_3    <= r_ovf_pend;
                    dot_2    <= r_ovf_pend;
                    dot_1    <= r_ovf_pend;
                    dot_0    <= r_ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
